// File: rtl/trap_monitor.sv
// rtl/trap_monitor.sv - end-of-simulation trap monitor: ebreak exit code, RV32I illegal decode, no-retire watchdog
// Optional TRAP_MONITOR_SIM_EN: prints a halt banner and calls $finish on entering HALT.
module trap_monitor #(
   parameter int XLEN            = 32,
   parameter int CNT_W           = 64,
   parameter int WATCHDOG_CYCLES = 1024,
   parameter int DRAIN_CYCLES    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inst_valid,
   input  logic [XLEN-1:0]  pc,
   input  logic [31:0]      instruction,
   input  logic [XLEN-1:0]  a0,
   output logic             halted,
   output logic [2:0]       trap_kind,
   output logic [XLEN-1:0]  trap_pc,
   output logic [31:0]      trap_inst,
   output logic [XLEN-1:0]  exit_code,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] inst_cnt
);
   localparam logic [31:0] EBREAK      = 32'h0010_0073;
   localparam logic [31:0] ECALL       = 32'h0000_0073;
   localparam logic [2:0]  K_NONE      = 3'd0;
   localparam logic [2:0]  K_GOOD      = 3'd1;
   localparam logic [2:0]  K_BAD_EXIT  = 3'd2;
   localparam logic [2:0]  K_ILLEGAL   = 3'd3;
   localparam logic [2:0]  K_TIMEOUT   = 3'd4;
   localparam logic [31:0] WD_LIMIT    = 32'(WATCHDOG_CYCLES);
   localparam logic [31:0] DRAIN_LIMIT = 32'(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

   state_t           r_state;
   logic             r_halted;
   logic [2:0]       r_kind;
   logic [XLEN-1:0]  r_trap_pc;
   logic [31:0]      r_trap_inst;
   logic [XLEN-1:0]  r_exit_code;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_inst_cnt;
   logic [31:0]      r_wd;
   logic [31:0]      r_drain;
   logic [XLEN-1:0]  r_last_pc;
   logic             w_legal;

   // Strict RV32I decode; the opcode match already requires low bits 2'b11.
   function automatic logic is_legal(input logic [31:0] w);
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = w[14:12];
      f7 = w[31:25];
      is_legal = 1'b0;
      case (w[6:0])
         7'b0110111, 7'b0010111, 7'b1101111: is_legal = 1'b1;
         7'b1100111: is_legal = (f3 == 3'd0);
         7'b1100011: is_legal = (f3 != 3'd2) && (f3 != 3'd3);
         7'b0000011: is_legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
         7'b0100011: is_legal = (f3 <= 3'd2);
         7'b0010011: begin
            case (f3)
               3'd1:    is_legal = (f7 == 7'h00);
               3'd5:    is_legal = (f7 == 7'h00) || (f7 == 7'h20);
               default: is_legal = 1'b1;
            endcase
         end
         7'b0110011: is_legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
         7'b0001111: is_legal = (f3 <= 3'd1);
         7'b1110011: is_legal = (w == ECALL) || (w == EBREAK) || ((f3 != 3'd0) && (f3 != 3'd4));
         default:    is_legal = 1'b0;
      endcase
   endfunction

   always_comb begin
      w_legal = is_legal(instruction);
   end

`ifdef TRAP_MONITOR_SIM_EN
   function automatic string cause_name(input logic [2:0] k);
      case (k)
         K_GOOD:     cause_name = "GOOD TRAP";
         K_BAD_EXIT: cause_name = "BAD EXIT";
         K_ILLEGAL:  cause_name = "ILLEGAL INSTRUCTION";
         K_TIMEOUT:  cause_name = "WATCHDOG TIMEOUT";
         default:    cause_name = "NONE";
      endcase
   endfunction
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_RUN;
         r_halted    <= 1'b0;
         r_kind      <= K_NONE;
         r_trap_pc   <= '0;
         r_trap_inst <= '0;
         r_exit_code <= '0;
         r_cycle_cnt <= '0;
         r_inst_cnt  <= '0;
         r_wd        <= '0;
         r_drain     <= '0;
         r_last_pc   <= '0;
      end else begin
         case (r_state)
            S_RUN: begin
               r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
               if (inst_valid) begin
                  if (instruction == EBREAK) begin
                     r_kind      <= (a0 == '0) ? K_GOOD : K_BAD_EXIT;
                     r_trap_pc   <= pc;
                     r_trap_inst <= instruction;
                     r_exit_code <= a0;
                     r_inst_cnt  <= r_inst_cnt + CNT_ONE;
                     r_state     <= S_DRAIN;
                  end else if (!w_legal) begin
                     r_kind      <= K_ILLEGAL;
                     r_trap_pc   <= pc;
                     r_trap_inst <= instruction;
                     r_state     <= S_DRAIN;
                  end else begin
                     r_inst_cnt  <= r_inst_cnt + CNT_ONE;
                     r_wd        <= '0;
                     r_last_pc   <= pc;
                  end
               end else if (WD_LIMIT != 32'd0) begin
                  // Trap on the edge where the idle count would reach the limit.
                  if (r_wd + 32'd1 == WD_LIMIT) begin
                     r_kind      <= K_TIMEOUT;
                     r_trap_pc   <= r_last_pc;
                     r_trap_inst <= '0;
                     r_state     <= S_DRAIN;
                  end else begin
                     r_wd <= r_wd + 32'd1;
                  end
               end
            end
            S_DRAIN: begin
               r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
               if (r_drain == DRAIN_LIMIT) begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
`ifdef TRAP_MONITOR_SIM_EN
                  if (r_kind == K_GOOD)
                     $display("\033[1;32m[trap_monitor] HIT %s pc=%h inst=%h exit=%0d cycles=%0d insts=%0d\033[0m",
                              cause_name(r_kind), r_trap_pc, r_trap_inst, r_exit_code,
                              r_cycle_cnt + CNT_ONE, r_inst_cnt);
                  else
                     $display("\033[1;31m[trap_monitor] HIT %s pc=%h inst=%h exit=%0d cycles=%0d insts=%0d\033[0m",
                              cause_name(r_kind), r_trap_pc, r_trap_inst, r_exit_code,
                              r_cycle_cnt + CNT_ONE, r_inst_cnt);
                  if (r_kind == K_GOOD) $finish(0);
                  else $finish(1);
`endif
               end else begin
                  r_drain <= r_drain + 32'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign halted    = r_halted;
   assign trap_kind = r_kind;
   assign trap_pc   = r_trap_pc;
   assign trap_inst = r_trap_inst;
   assign exit_code = r_exit_code;
   assign cycle_cnt = r_cycle_cnt;
   assign inst_cnt  = r_inst_cnt;
endmodule

// File: tb/tb_trap_monitor.sv
// tb/tb_trap_monitor.sv - scoreboard bench for trap_monitor (WATCHDOG_CYCLES=8, DRAIN_CYCLES=2)
module tb_trap_monitor;
   localparam int XLEN = 32;
   localparam int CNT_W = 64;
   localparam logic [2:0] K_NONE = 3'd0, K_GOOD = 3'd1, K_BAD = 3'd2, K_ILL = 3'd3, K_TO = 3'd4;
   localparam logic [31:0] ADDI = 32'h0010_0093;
   localparam logic [31:0] EBRK = 32'h0010_0073;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             inst_valid = 1'b0;
   logic [31:0]      pc = '0;
   logic [31:0]      instruction = '0;
   logic [31:0]      a0 = '0;
   logic             halted;
   logic [2:0]       trap_kind;
   logic [31:0]      trap_pc;
   logic [31:0]      trap_inst;
   logic [31:0]      exit_code;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] inst_cnt;

   typedef struct packed {
      logic [2:0]  kind;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] code;
      logic [63:0] icnt;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_fail = 0;

   logic [31:0] ill_words [0:9] = '{32'h0000_7003, 32'h4000_1033, 32'h0000_0000, 32'h0000_2063,
                                    32'h0000_3023, 32'h0200_1013, 32'h0000_4073, 32'h0000_1067,
                                    32'h0020_0073, 32'h0000_0011};
   logic [31:0] legal_words [0:11] = '{32'h4000_5013, 32'h4000_0033, 32'h0000_0073, 32'h0000_1073,
                                       32'h0000_100F, 32'h0000_0067, 32'h0000_0063, 32'h0000_0037,
                                       32'h0000_5003, 32'h0000_006F, 32'h0000_7073, 32'h4000_5033};

   always #5 clk = ~clk;

   trap_monitor #(.XLEN(XLEN), .CNT_W(CNT_W), .WATCHDOG_CYCLES(8), .DRAIN_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc(pc), .instruction(instruction), .a0(a0),
      .halted(halted), .trap_kind(trap_kind), .trap_pc(trap_pc), .trap_inst(trap_inst),
      .exit_code(exit_code), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; inst_valid = 1'b0; pc = '0; instruction = '0; a0 = '0;
      step();
      rst = 1'b1;
   endtask

   task automatic retire(input logic [31:0] p, input logic [31:0] w, input logic [31:0] v);
      inst_valid = 1'b1; pc = p; instruction = w; a0 = v;
      step();
      inst_valid = 1'b0;
   endtask

   task automatic run_until_trap(input int budget, output int waited);
      waited = 0;
      while (trap_kind == K_NONE && waited < budget) begin
         step();
         waited++;
      end
   endtask

   task automatic run_until_halt(input int budget, output int waited);
      waited = 0;
      while (halted !== 1'b1 && waited < budget) begin
         step();
         waited++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) step();
      n_cmp++;
      if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
      n_cmp++;
      if ({trap_kind, trap_pc, trap_inst, exit_code} !== '0) begin
         n_fail++;
         $display("FAIL reset_trap_fields: got kind=%0d pc=%h inst=%h code=%h expected all 0", trap_kind, trap_pc, trap_inst, exit_code);
      end
      n_cmp++;
      if (cycle_cnt !== 64'd0 || inst_cnt !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_counters: got cycle=%0d inst=%0d expected 0/0", cycle_cnt, inst_cnt);
      end
   endtask

   task automatic test_good_trap();
      int w;
      exp_t e;
      do_reset();
      for (int i = 0; i < 10; i++) retire(32'h8000_0000 + 32'(4 * i), ADDI, 32'd0);
      sb.push_back('{K_GOOD, 32'h8000_0028, EBRK, 32'd0, 64'd11});
      retire(32'h8000_0028, EBRK, 32'd0);
      run_until_trap(4, w);
      e = sb.pop_front();
      n_cmp++;
      if (w != 0 || {trap_kind, trap_pc, trap_inst, exit_code, inst_cnt} !== {e.kind, e.pc, e.inst, e.code, e.icnt}) begin
         n_fail++;
         $display("FAIL good_trap: got wait=%0d kind=%0d pc=%h inst=%h code=%h icnt=%0d expected wait=0 kind=%0d pc=%h inst=%h code=%h icnt=%0d",
                  w, trap_kind, trap_pc, trap_inst, exit_code, inst_cnt, e.kind, e.pc, e.inst, e.code, e.icnt);
      end
      n_cmp++;
      if (cycle_cnt !== 64'd11 || halted !== 1'b0) begin
         n_fail++; $display("FAIL good_trap_cycle: got cycle=%0d halted=%b expected 11/0", cycle_cnt, halted);
      end
      run_until_halt(10, w);
      n_cmp++;
      if (w != 3 || cycle_cnt !== 64'd14) begin
         n_fail++; $display("FAIL good_halt_latency: got edges=%0d cycle=%0d expected 3/14", w, cycle_cnt);
      end
      retire(32'h9000_0000, ADDI, 32'd0);
      retire(32'h9000_0004, EBRK, 32'd9);
      n_cmp++;
      if (halted !== 1'b1 || inst_cnt !== 64'd11 || cycle_cnt !== 64'd14 || trap_kind !== K_GOOD || trap_pc !== 32'h8000_0028) begin
         n_fail++;
         $display("FAIL halt_frozen: got halted=%b icnt=%0d cycle=%0d kind=%0d pc=%h expected 1/11/14/1/80000028",
                  halted, inst_cnt, cycle_cnt, trap_kind, trap_pc);
      end
   endtask

   task automatic test_bad_exit();
      int w;
      exp_t e;
      do_reset();
      sb.push_back('{K_BAD, 32'h0000_0100, EBRK, 32'd5, 64'd1});
      retire(32'h0000_0100, EBRK, 32'd5);
      run_until_trap(4, w);
      e = sb.pop_front();
      n_cmp++;
      if (w != 0 || {trap_kind, trap_pc, trap_inst, exit_code, inst_cnt} !== {e.kind, e.pc, e.inst, e.code, e.icnt}) begin
         n_fail++;
         $display("FAIL bad_exit: got wait=%0d kind=%0d pc=%h inst=%h code=%h icnt=%0d expected wait=0 kind=%0d pc=%h inst=%h code=%h icnt=%0d",
                  w, trap_kind, trap_pc, trap_inst, exit_code, inst_cnt, e.kind, e.pc, e.inst, e.code, e.icnt);
      end
      run_until_halt(10, w);
      n_cmp++;
      if (w != 3) begin n_fail++; $display("FAIL bad_exit_halt: got edges=%0d expected 3", w); end
   endtask

   task automatic test_illegal();
      int w;
      exp_t e;
      logic [63:0] icnt;
      logic [31:0] p;
      for (int i = 0; i < 10; i++) begin
         do_reset();
         icnt = 64'd0;
         if (i == 0) begin
            retire(32'h0000_1000, 32'h0000_A003, 32'd0);
            icnt = 64'd1;
         end
         p = 32'h0000_2000 + 32'(16 * i);
         sb.push_back('{K_ILL, p, ill_words[i], 32'd0, icnt});
         retire(p, ill_words[i], 32'h33);
         run_until_trap(4, w);
         e = sb.pop_front();
         n_cmp++;
         if (w != 0 || {trap_kind, trap_pc, trap_inst, exit_code, inst_cnt} !== {e.kind, e.pc, e.inst, e.code, e.icnt}) begin
            n_fail++;
            $display("FAIL illegal_%0d: got wait=%0d kind=%0d pc=%h inst=%h code=%h icnt=%0d expected wait=0 kind=%0d pc=%h inst=%h code=%h icnt=%0d",
                     i, w, trap_kind, trap_pc, trap_inst, exit_code, inst_cnt, e.kind, e.pc, e.inst, e.code, e.icnt);
         end
      end
   endtask

   task automatic test_legal_sweep();
      do_reset();
      for (int i = 0; i < 12; i++) retire(32'h0000_3000 + 32'(4 * i), legal_words[i], 32'd0);
      n_cmp++;
      if (trap_kind !== K_NONE || inst_cnt !== 64'd12 || cycle_cnt !== 64'd12) begin
         n_fail++;
         $display("FAIL legal_sweep: got kind=%0d icnt=%0d cycle=%0d expected 0/12/12", trap_kind, inst_cnt, cycle_cnt);
      end
   endtask

   task automatic test_watchdog();
      int w;
      exp_t e;
      do_reset();
      sb.push_back('{K_TO, 32'd0, 32'd0, 32'd0, 64'd0});
      run_until_trap(20, w);
      e = sb.pop_front();
      n_cmp++;
      if (w != 8 || {trap_kind, trap_pc, trap_inst, exit_code, inst_cnt} !== {e.kind, e.pc, e.inst, e.code, e.icnt}) begin
         n_fail++;
         $display("FAIL watchdog_from_reset: got edges=%0d kind=%0d pc=%h inst=%h icnt=%0d expected edges=8 kind=%0d pc=%h inst=%h icnt=%0d",
                  w, trap_kind, trap_pc, trap_inst, inst_cnt, e.kind, e.pc, e.inst, e.icnt);
      end
      do_reset();
      retire(32'h8000_0000, ADDI, 32'd0);
      sb.push_back('{K_TO, 32'h8000_0000, 32'd0, 32'd0, 64'd1});
      run_until_trap(20, w);
      e = sb.pop_front();
      n_cmp++;
      if (w != 8 || {trap_kind, trap_pc, trap_inst, exit_code, inst_cnt} !== {e.kind, e.pc, e.inst, e.code, e.icnt}) begin
         n_fail++;
         $display("FAIL watchdog_after_retire: got edges=%0d kind=%0d pc=%h inst=%h icnt=%0d expected edges=8 kind=%0d pc=%h inst=%h icnt=%0d",
                  w, trap_kind, trap_pc, trap_inst, inst_cnt, e.kind, e.pc, e.inst, e.icnt);
      end
      run_until_halt(10, w);
      n_cmp++;
      if (w != 3) begin n_fail++; $display("FAIL watchdog_halt: got edges=%0d expected 3", w); end
      do_reset();
      retire(32'h8000_0000, ADDI, 32'd0);
      repeat (7) step();
      retire(32'h8000_0004, ADDI, 32'd0);
      repeat (7) step();
      n_cmp++;
      if (trap_kind !== K_NONE) begin n_fail++; $display("FAIL watchdog_rearm: got kind=%0d expected 0", trap_kind); end
      step();
      n_cmp++;
      if (trap_kind !== K_TO || trap_pc !== 32'h8000_0004) begin
         n_fail++; $display("FAIL watchdog_limit: got kind=%0d pc=%h expected 4/80000004", trap_kind, trap_pc);
      end
   endtask

   task automatic test_drain_ignore_and_reset();
      int w;
      exp_t e;
      do_reset();
      sb.push_back('{K_GOOD, 32'h0000_0500, EBRK, 32'd0, 64'd1});
      retire(32'h0000_0500, EBRK, 32'd0);
      run_until_trap(4, w);
      e = sb.pop_front();
      n_cmp++;
      if (w != 0 || {trap_kind, trap_pc, trap_inst, exit_code, inst_cnt} !== {e.kind, e.pc, e.inst, e.code, e.icnt}) begin
         n_fail++;
         $display("FAIL drain_setup: got kind=%0d pc=%h code=%h icnt=%0d expected kind=%0d pc=%h code=%h icnt=%0d",
                  trap_kind, trap_pc, exit_code, inst_cnt, e.kind, e.pc, e.code, e.icnt);
      end
      retire(32'h0000_0600, EBRK, 32'd7);
      n_cmp++;
      if (trap_pc !== 32'h0000_0500 || exit_code !== 32'd0 || inst_cnt !== 64'd1 || trap_kind !== K_GOOD || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_ignores_ebreak: got pc=%h code=%0d icnt=%0d kind=%0d halted=%b expected 500/0/1/1/0",
                  trap_pc, exit_code, inst_cnt, trap_kind, halted);
      end
      rst = 1'b0;
      step();
      rst = 1'b1;
      n_cmp++;
      if ({halted, trap_kind, trap_pc, trap_inst, exit_code, cycle_cnt, inst_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_in_drain: got halted=%b kind=%0d pc=%h code=%h cycle=%0d icnt=%0d expected all 0",
                  halted, trap_kind, trap_pc, exit_code, cycle_cnt, inst_cnt);
      end
      step();
      n_cmp++;
      if (cycle_cnt !== 64'd1 || trap_kind !== K_NONE) begin
         n_fail++; $display("FAIL counters_restart: got cycle=%0d kind=%0d expected 1/0", cycle_cnt, trap_kind);
      end
      retire(32'h0000_0700, EBRK, 32'd0);
      run_until_halt(10, w);
      rst = 1'b0;
      step();
      rst = 1'b1;
      n_cmp++;
      if (halted !== 1'b0 || cycle_cnt !== 64'd0 || trap_kind !== K_NONE || inst_cnt !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_in_halt: got halted=%b cycle=%0d kind=%0d icnt=%0d expected 0/0/0/0", halted, cycle_cnt, trap_kind, inst_cnt);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_good_trap();
      test_bad_exit();
      test_illegal();
      test_legal_sweep();
      test_watchdog();
      test_drain_ignore_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/trap_monitor.md
# trap_monitor

Parametrised end-of-simulation monitor for the NPC core. It observes every retired instruction and performs three checks:
- `ebreak` with the `a0` exit-code convention (good or bad trap);
- strict RV32I illegal-instruction decode on opcode, funct3 and funct7;
- a no-retire watchdog.

After a trap it drains for a configurable number of cycles, then latches a sticky halt with the cause, PC, instruction and exit code. It keeps cycle and retired-instruction counters so the testbench and C++ harness can report IPC.

## Interface
Parameters:
- `XLEN`, default 32, width of `pc`, `a0`, `exit_code` and `trap_pc`.
- `CNT_W`, default 64, width of the cycle and instruction counters.
- `WATCHDOG_CYCLES`, default 1024. Consecutive non-retire cycles before a timeout trap; 0 disables the watchdog.
- `DRAIN_CYCLES`, default 2. Cycles spent in DRAIN before HALT; 0 is legal.

Ports:
- `clk` input, 1 bit: core clock, all logic on the rising edge.
- `rst` input, 1 bit: reset, synchronous, active-low.
- `inst_valid` input, 1 bit: an instruction retires this cycle.
- `pc` input, `XLEN` bits: PC of the retiring instruction.
- `instruction` input, 32 bits: the retiring instruction word.
- `a0` input, `XLEN` bits: current value of x10, sampled with an `ebreak`.
- `halted` output, 1 bit: sticky halt flag.
- `trap_kind` output, 3 bits. Encoding: 0 NONE, 1 GOOD, 2 BAD_EXIT, 3 ILLEGAL, 4 TIMEOUT.
- `trap_pc` output, `XLEN` bits: PC captured at the trap.
- `trap_inst` output, 32 bits: instruction captured at the trap (0 for TIMEOUT).
- `exit_code` output, `XLEN` bits: `a0` captured at an `ebreak`; 0 otherwise.
- `cycle_cnt` output, `CNT_W` bits: cycles spent in RUN plus DRAIN.
- `inst_cnt` output, `CNT_W` bits: retired instructions counted in RUN.

## Operation
- The state machine has three states: RUN, DRAIN and HALT. Reset (`rst`=0 at a rising edge) forces RUN and clears all outputs, counters, the watchdog counter and the drain counter to 0, regardless of the current state.
- RUN, checks on `inst_valid`=1, in priority order:
  - `instruction`==32'h00100073 (`ebreak`): capture `pc`, `instruction` and `a0`. `trap_kind` becomes GOOD if `a0`==0, else BAD_EXIT. `inst_cnt` increments. Go to DRAIN.
  - Otherwise, if the instruction is illegal: capture `pc` and `instruction`, set `trap_kind`=ILLEGAL. `inst_cnt` does not increment. Go to DRAIN.
  - Otherwise: `inst_cnt` increments and the watchdog counter clears.
- RUN, watchdog on `inst_valid`=0: the watchdog counter increments. When it would reach `WATCHDOG_CYCLES`, set `trap_kind`=TIMEOUT, capture the last retired PC (0 if none retired), `trap_inst`=0, and go to DRAIN.
- The illegal-instruction decode treats the following as legal; anything else is illegal:
  - Low two bits 2'b11 is a prerequisite for every legal encoding.
  - LUI, AUIPC and JAL: any encoding with these opcodes.
  - JALR: funct3=0.
  - BRANCH: funct3 other than 2 or 3.
  - LOAD: funct3 in {0,1,2,4,5}.
  - STORE: funct3 in {0,1,2}.
  - OP-IMM: any funct3, except SLLI needs funct7=0 and SRLI/SRAI need funct7 in {0x00,0x20}.
  - OP: funct7=0x00, or funct7=0x20 with funct3 in {0,5}.
  - MISC-MEM: funct3 in {0,1}.
  - SYSTEM: `ecall` or `ebreak` exact encodings, or a CSR funct3 in {1,2,3,5,6,7}.
- DRAIN: the drain counter counts up to `DRAIN_CYCLES`, then the block enters HALT. `inst_valid` is ignored; captured fields do not change.
- HALT: `halted`=1, all outputs frozen, and the block stays here until reset.
- Counters: `cycle_cnt` increments every cycle in RUN and DRAIN and freezes in HALT. Both counters wrap modulo 2^`CNT_W`.

## Timing
- A trap condition sampled at edge T makes `trap_kind`, `trap_pc`, `trap_inst` and `exit_code` visible after edge T.
- If `DRAIN_CYCLES`=0, `halted` is 1 after edge T+1.
- Otherwise `halted` rises after edge T+1+`DRAIN_CYCLES`.
- Watchdog: with the last retire at edge R and no retire after it, TIMEOUT is registered at edge R+`WATCHDOG_CYCLES`.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset applied mid-DRAIN or in HALT takes effect at that edge; the next cycle is RUN with everything zero.

## Configuration
- `TRAP_MONITOR_SIM_EN` defined:
  - On the edge entering HALT, print a banner with the cause, PC, instruction, exit code, `cycle_cnt` and `inst_cnt`. GOOD prints in green; all other causes print in red.
  - Then call `$finish(0)` for GOOD and `$finish(1)` for every other cause.
- Undefined: no system tasks; the block is synthesizable and reports only through its ports.

## Test plan
- Retire 10 ADDI (0x00100093), then `ebreak` with `a0`=0, `DRAIN_CYCLES`=2. Expect: `trap_kind`=GOOD, `inst_cnt`=11, `halted` rising 3 edges after the `ebreak` edge, and `$finish(0)` with the macro defined.
- `ebreak` with `a0`=5. Expect: BAD_EXIT, `exit_code`=5, `$finish(1)`.
- Illegal words, each from reset:
  - 0x0000A003 (LOAD funct3=2, legal) then 0x00007003 (LOAD funct3=7). Expect ILLEGAL on the second, `trap_pc` equal to its PC, `inst_cnt`=1.
  - 0x40001033 (SLL with funct7=0x20). Expect ILLEGAL.
  - 0x00000000. Expect ILLEGAL.
- `WATCHDOG_CYCLES`=8: one retire at PC 0x80000000, then `inst_valid`=0. Expect TIMEOUT registered 8 edges later, `trap_pc`=0x80000000, `trap_inst`=0.
- Reset mid-operation and ignored retires:
  - Assert `rst`=0 for one cycle during DRAIN. Expect RUN, all outputs 0, and counters restarting.
  - An `ebreak` presented during DRAIN is ignored.
